// File: rtl/p2s_serializer_pkg.sv
// Shared definitions for the P2S/S2P serial link: FSM encoding and default widths.
package p2s_serializer_pkg;

  localparam int IN_PORT_WIDTH = 4;
  localparam int COUNTER_WIDTH = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/p2s_serializer_if.sv
// Word-in / bit-out handshake bundle for the parallel-to-serial converter.
interface p2s_serializer_if
  import p2s_serializer_pkg::*;
#(
    parameter int inPortWidth = IN_PORT_WIDTH
);
    logic [inPortWidth-1:0] parallelIn;
    logic                   inValid;
    logic                   inReady;
    logic                   enable;
    logic                   serialOut;
    logic                   serialValid;
    logic                   done;
    logic                   busy;

    modport slave (
        input  parallelIn, inValid, enable,
        output inReady, serialOut, serialValid, done, busy
    );

    modport master (
        output parallelIn, inValid, enable,
        input  inReady, serialOut, serialValid, done, busy
    );
endinterface

// File: rtl/p2s_serializer.sv
// Parallel-to-serial converter: one-word hold stage feeding an LSB-first shifter.
// Words arriving while the shifter runs are reloaded with no gap between words.
module p2s_serializer
  import p2s_serializer_pkg::*;
#(
    parameter int inPortWidth  = IN_PORT_WIDTH,
    parameter int counterWidth = COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    p2s_serializer_if.slave  bus
);

    localparam logic [counterWidth-1:0] LAST_BIT = counterWidth'(inPortWidth - 1);

    state_t                  r_state, w_state_nxt;
    logic [inPortWidth-1:0]  r_hold, w_hold_nxt;
    logic [inPortWidth-1:0]  r_shift, w_shift_nxt;
    logic [counterWidth-1:0] r_cnt, w_cnt_nxt;
    logic                    r_holdFull, w_holdFull_nxt;

    logic w_accept;
    logic w_last;
    logic w_xfer;

    // inReady comes straight from r_holdFull, so accept cannot coincide with transfer
    assign w_accept = bus.inValid && !r_holdFull;
    assign w_last   = (r_state == SHIFT) && (r_cnt == LAST_BIT);
    assign w_xfer   = r_holdFull && bus.enable && ((r_state == IDLE) || w_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_hold     <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_holdFull <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_holdFull <= w_holdFull_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_nxt     = r_hold;
        w_shift_nxt    = r_shift;
        w_cnt_nxt      = r_cnt;
        w_holdFull_nxt = r_holdFull;

        if (w_accept) begin
            w_hold_nxt     = bus.parallelIn;
            w_holdFull_nxt = 1'b1;
        end

        if (w_xfer) begin
            w_shift_nxt    = r_hold;
            w_cnt_nxt      = '0;
            w_state_nxt    = SHIFT;
            w_holdFull_nxt = 1'b0;
        end else if ((r_state == SHIFT) && bus.enable) begin
            if (w_last) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_shift_nxt = r_shift >> 1;
                w_cnt_nxt   = r_cnt + counterWidth'(1);
            end
        end
    end

    assign bus.inReady     = !r_holdFull;
    assign bus.serialOut   = (r_state == SHIFT) ? r_shift[0] : 1'b0;
    assign bus.serialValid = (r_state == SHIFT) && bus.enable;
    assign bus.done        = bus.serialValid && (r_cnt == LAST_BIT);
    assign bus.busy        = (r_state != IDLE) || r_holdFull;

endmodule

// File: doc/p2s_serializer.md
Name: p2s_serializer

Overview:
Parallel-to-serial converter: the transmit-side counterpart of the team's serial-to-parallel converter. It accepts inPortWidth-bit words over a valid/ready handshake, buffers one word, and shifts each word out LSB-first, one bit per clock. Bit order matches the S2P block, so this block followed by S2P round-trips a word unchanged. It feeds the baseband modulator bit stream from symbol/word-level upstream logic.

Parameters:
inPortWidth, 4, input word width in bits (≥2)
counterWidth, 2, bit-counter width = log2(inPortWidth)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
parallelIn  input  inPortWidth  word to serialize
inValid  input  1  parallelIn holds a valid word
inReady  output  1  block can accept a word this cycle
enable  input  1  shift enable; low stalls the serial stream
serialOut  output  1  current serial bit
serialValid  output  1  serialOut holds a valid bit this cycle
done  output  1  one-cycle pulse coincident with a word's last bit
busy  output  1  high while SHIFT or holding a word

Behaviour:
- Reset (rst low, async): state=IDLE; holdReg, shiftReg, bitCnt, holdFull = 0. Outputs: serialOut=0, serialValid=0, done=0, busy=0, inReady=1.
- Reset mid-word discards the partial word and any held word. No bit is emitted after reset asserts.
- Hold stage (1 entry):
  - inReady = !holdFull. This is a register output with no combinational path from inValid or enable.
  - Accept at an edge where inValid && inReady: holdReg<=parallelIn, holdFull<=1.
  - Accept and transfer can never coincide, because transfer requires holdFull=1.
- Transfer condition T = holdFull && enable && (state==IDLE || (state==SHIFT && bitCnt==inPortWidth-1)). On T: shiftReg<=holdReg, bitCnt<=0, state<=SHIFT, holdFull<=0.
- FSM states and transitions:
  - IDLE → SHIFT on T.
  - SHIFT, enable=1, bitCnt<inPortWidth-1: shiftReg>>=1, bitCnt++.
  - SHIFT, enable=1, bitCnt==inPortWidth-1, T true: reload from holdReg. The next word starts the next cycle with no gap.
  - SHIFT, enable=1, bitCnt==inPortWidth-1, T false: go to IDLE.
  - SHIFT, enable=0: state, shiftReg and bitCnt frozen.
- Outputs:
  - serialOut = shiftReg[0] when state==SHIFT, else 0.
  - serialValid = (state==SHIFT) && enable.
  - done = serialValid && bitCnt==inPortWidth-1.
  - busy = (state!=IDLE) || holdFull.
- Latency: a word accepted at edge E appears as bit0 in the cycle after E+1 (enable=1). Bit i appears in cycle E+1+i; done is high in cycle E+inPortWidth.
- Throughput: 1 bit/clk sustained when upstream refills the hold stage within each word period.
- enable low:
  - Hold-stage acceptance still proceeds.
  - An accepted word waits in IDLE until enable=1.
  - A stall on the last bit holds done low until enable returns; done then pulses exactly once.
- bitCnt is counterWidth bits and never wraps beyond inPortWidth-1.

Decomposition:
- Shared package holds the FSM state encoding (IDLE=1'b0, SHIFT=1'b1) and the default width constants (inPortWidth, counterWidth), shared with the S2P block.
- No sub-module. The hold stage and the shifter stay in one module; a separate one-entry buffer module is not justified.

Test Plan:
- Reset then a single word: parallelIn=4'b1011 with inValid for 1 cycle → inReady drops next cycle; serialOut = 1,1,0,1 over 4 consecutive serialValid cycles starting 2 edges after accept; done high on the 4th; busy back to 0 afterward.
- Back-to-back: inValid held high with 4'b0110 then 4'b1001 → 8 contiguous valid bits 0,1,1,0,1,0,0,1 with no serialValid gap; done pulses at bits 4 and 8.
- Stall: during 4'b1100, drop enable for 3 cycles after bit1 → serialValid low for 3 cycles, then bits 1,1 resume; done pulses exactly once.
- Enable low at accept: accept 4'b0001 with enable=0 for 5 cycles → busy=1, inReady=0, no serialValid; first bit 1 appears the cycle after enable rises +1 edge.
- Async reset mid-word: assert rst during bit2 of 4'b1111 → all outputs go to reset values immediately, with no glitch on serialValid; a new word after release serializes correctly.
- Loopback: P2S serialOut → S2P serialIn, with S2P start = serialValid; random 100 words → S2P parallelOut sequence equals the input sequence.
